// File: rtl/v2f_seq_divmod.sv
// v2f_seq_divmod: multi-cycle radix-2 restoring divider, quotient and remainder together.
// Valid/ready on both sides; one operation in flight. One quotient bit per CALC cycle.
// A divide-by-zero goes straight to DONE with quot=rem=0 and dbz=1.
//
// Optional feature macro: V2F_SEQ_DIVMOD_SIGNED_EN
//   defined     - a_signed=1 divides two's-complement operands, truncating toward zero
//   not defined - a_signed is ignored and all operands are unsigned
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, a_signed       dividend, divisor, signed-operation select
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   quot, rem, dbz       quotient, remainder, divide-by-zero flag (held until next result)
module v2f_seq_divmod #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   div_sh;   // dividend bits shift out of the top, quotient bits shift in
    logic [WIDTH-1:0]   rem_acc;
    logic [WIDTH-1:0]   div_mag;

    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH:0]     partial_c;
    logic               take_c;
    logic [WIDTH-1:0]   rem_step_c;
    logic [WIDTH-1:0]   q_step_c;
    logic [WIDTH-1:0]   q_fin_c;
    logic [WIDTH-1:0]   r_fin_c;

`ifdef V2F_SEQ_DIVMOD_SIGNED_EN
    logic               neg_q;
    logic               neg_r;
    logic               a_neg_c;
    logic               b_neg_c;

    // Operand magnitudes; MIN_INT maps to itself, which is its correct unsigned magnitude
    always_comb begin
        a_neg_c = a_signed & a[WIDTH-1];
        b_neg_c = a_signed & b[WIDTH-1];
        a_mag_c = a_neg_c ? WIDTH'(-a) : a;
        b_mag_c = b_neg_c ? WIDTH'(-b) : b;
    end
`else
    logic               unused_a_signed;

    assign unused_a_signed = a_signed;

    always_comb begin
        a_mag_c = a;
        b_mag_c = b;
    end
`endif

    // One restoring step; the final step also feeds the result registers directly
    always_comb begin
        partial_c  = {rem_acc, div_sh[WIDTH-1]};
        take_c     = (partial_c >= {1'b0, div_mag});
        rem_step_c = take_c ? WIDTH'(partial_c - {1'b0, div_mag}) : partial_c[WIDTH-1:0];
        q_step_c   = {div_sh[WIDTH-2:0], take_c};
`ifdef V2F_SEQ_DIVMOD_SIGNED_EN
        q_fin_c    = neg_q ? WIDTH'(-q_step_c) : q_step_c;
        r_fin_c    = neg_r ? WIDTH'(-rem_step_c) : rem_step_c;
`else
        q_fin_c    = q_step_c;
        r_fin_c    = rem_step_c;
`endif
    end

    // Control FSM, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            dbz       <= 1'b0;
            cnt       <= '0;
            div_sh    <= '0;
            rem_acc   <= '0;
            div_mag   <= '0;
`ifdef V2F_SEQ_DIVMOD_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (b == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quot      <= '0;
                            rem       <= '0;
                            dbz       <= 1'b1;
                        end else begin
                            state   <= CALC;
                            cnt     <= '0;
                            div_sh  <= a_mag_c;
                            div_mag <= b_mag_c;
                            rem_acc <= '0;
`ifdef V2F_SEQ_DIVMOD_SIGNED_EN
                            neg_q   <= a_neg_c ^ b_neg_c;
                            neg_r   <= a_neg_c;
`endif
                        end
                    end
                end
                CALC: begin
                    div_sh  <= q_step_c;
                    rem_acc <= rem_step_c;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // Last step: counter holds, results land with sign fix applied
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quot      <= q_fin_c;
                        rem       <= r_fin_c;
                        dbz       <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v2f_seq_divmod.sv
// Self-checking bench for v2f_seq_divmod: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model, with random backpressure.
module tb_v2f_seq_divmod;

    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        a_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dbz;

    int checks = 0;
    int failures = 0;

    v2f_seq_divmod #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: ordinary division semantics, truncation toward zero, remainder takes dividend sign
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                         output logic [31:0] q, output logic [31:0] r, output logic d);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = ma;
        sb = mb;
        d  = 1'b0;
        if (mb == 32'd0) begin
            q = '0;
            r = '0;
            d = 1'b1;
        end else begin
            q = ma / mb;
            r = ma % mb;
`ifdef V2F_SEQ_DIVMOD_SIGNED_EN
            if (ms) begin
                if (ma == MIN_INT && mb == 32'hFFFF_FFFF) begin
                    q = MIN_INT;
                    r = '0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end
`else
            if (ms && (sa == sb) && (sa != sb)) q = '0;   // a_signed has no effect in this build
`endif
        end
    endtask

    // One full operation: accept, wait for result, optional backpressure, output handshake
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                         input int hold);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ed;
        int          cyc;
        model(oa, ob, os, eq, er, ed);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = oa;
        b        = ob;
        a_signed = os;
        @(posedge clk);
        @(negedge clk);
        a        = $urandom;
        b        = $urandom;
        a_signed = 1'($urandom);
        in_valid = 1'($urandom);
        cyc      = 1;
        if (ob != 32'd0) check("in_ready_calc", 32'(in_ready), 32'd0);
        while (!out_valid && cyc < 200) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("latency", 32'(cyc), (ob == 32'd0) ? 32'd1 : 32'(WIDTH + 1));
        check("quot", quot, eq);
        check("rem", rem, er);
        check("dbz", 32'(dbz), 32'(ed));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
        end
        if (hold > 0) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quot", quot, eq);
            check("hold_rem", rem, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_quot", quot, eq);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd100, 32'd7, 1'b0, 0);
        do_op(32'd5, 32'd0, 1'b0, 2);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_op(MIN_INT, 32'hFFFF_FFFF, 1'b1, 1);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_op(32'd3, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'd123456, 32'd1000, 1'b0, 50);

        // Reset in the middle of CALC aborts the operation
        check("pre_abort_quot", quot, 32'd123);
        in_valid = 1'b1;
        a        = 32'd999;
        b        = 32'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_quot", quot, 32'd0);
        check("abort_rem", rem, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'd1000, 32'd33, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            ra  = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      rb = 32'd0;
            else if (sel < 3)  rb = 32'($urandom_range(1, 20));
            else if (sel == 3) rb = 32'hFFFF_FFFF;
            else               rb = $urandom;
            if (sel == 4) ra = MIN_INT;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
